// File: rtl/key_debounce_pkg.sv
// Shared definitions for the multi-key debouncer:
// channel FSM state encodings and the counter-width helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Bits needed to hold every value 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: synchroniser, debounce FSM, hold and repeat timers.
// Ports: clk_i/rst_i (async, active-high), key_i raw level, repeat_en_i;
// level_o debounced level, press_o/release_o/long_o/repeat_o 1-cycle pulses.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 9,
    parameter int LONG_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);
    localparam int REP_W  = cnt_width(REPEAT_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    key_state_e        state_q;
    logic [DEB_W-1:0]  deb_q;
    logic [HOLD_W-1:0] hold_q;
    logic [REP_W-1:0]  rep_q;
    logic              armed_q;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              repeat_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            armed_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    deb_q <= '0;
                    if (s) begin
                        state_q <= ST_PRESS_WAIT;
                        deb_q   <= DEB_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= ST_IDLE;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q <= ST_PRESSED;
                        deb_q   <= '0;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
                        hold_q  <= '0;
                        rep_q   <= '0;
                        armed_q <= 1'b0;
                    end else begin
                        deb_q <= deb_q + DEB_ONE;
                    end
                end
                ST_PRESSED: begin
                    // Timers advance on every PRESSED cycle, including the
                    // one that leaves for RELEASE_WAIT; they freeze there.
                    if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                    if (!armed_q && hold_q == HOLD_LAST) begin
                        long_q  <= 1'b1;
                        armed_q <= 1'b1;
                        rep_q   <= '0;
                    end else if (armed_q) begin
                        if (!repeat_en_i) begin
                            rep_q <= '0;
                        end else if (rep_q == REP_LAST) begin
                            rep_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            rep_q <= rep_q + REP_W'(1);
                        end
                    end
                    if (!s) begin
                        state_q <= ST_RELEASE_WAIT;
                        deb_q   <= DEB_ONE;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        // Glitch: resume with hold/repeat untouched.
                        state_q <= ST_PRESSED;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q   <= ST_IDLE;
                        deb_q     <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                        hold_q    <= '0;
                        rep_q     <= '0;
                        armed_q   <= 1'b0;
                    end else begin
                        deb_q <= deb_q + DEB_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    deb_q   <= '0;
                    hold_q  <= '0;
                    rep_q   <= '0;
                    armed_q <= 1'b0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: N_KEYS independent channels.
// Ports: CLK, RST (async, active-high), keys_in, repeat_en;
// level_out, press_out, release_out, long_out, repeat_out per channel.
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 9,
    parameter int LONG_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] level_out,
    output logic [N_KEYS-1:0] press_out,
    output logic [N_KEYS-1:0] release_out,
    output logic [N_KEYS-1:0] long_out,
    output logic [N_KEYS-1:0] repeat_out
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        key_debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk_i      (CLK),
            .rst_i      (RST),
            .key_i      (keys_in[k]),
            .repeat_en_i(repeat_en[k]),
            .level_o    (level_out[k]),
            .press_o    (press_out[k]),
            .release_o  (release_out[k]),
            .long_o     (long_out[k]),
            .repeat_o   (repeat_out[k])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: run-length reference model compared
// every cycle, plus directed latency scenarios with literal expectations.
module tb_key_debounce_multi;

    localparam int NK = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int LC = 20;
    localparam int RC = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NK-1:0] keys_in = '0;
    logic [NK-1:0] repeat_en = '0;
    logic [NK-1:0] level_out, press_out, release_out, long_out, repeat_out;

    always #5 CLK = ~CLK;

    key_debounce_multi #(
        .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
    ) dut (
        .CLK(CLK), .RST(RST), .keys_in(keys_in), .repeat_en(repeat_en),
        .level_out(level_out), .press_out(press_out),
        .release_out(release_out), .long_out(long_out),
        .repeat_out(repeat_out)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: shift history of raw samples, a run length of
    // samples disagreeing with the accepted level, and edge counters.
    bit m_sh [NK][SS];
    bit m_lvl [NK];
    int m_run [NK];
    int m_hold [NK];
    int m_rep [NK];
    bit m_arm [NK];
    bit m_s;
    logic [NK-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_lng = '0, e_rpt = '0;

    int cnt_prs [NK];
    int cnt_rel [NK];
    int cnt_lng [NK];
    int cnt_rpt [NK];

    task automatic model_step();
        e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
        for (int k = 0; k < NK; k++) begin
            m_s = m_sh[k][SS-1];
            for (int j = SS - 1; j > 0; j--) m_sh[k][j] = m_sh[k][j-1];
            m_sh[k][0] = keys_in[k];
            // key considered held with no pending release candidate
            if (m_lvl[k] && m_run[k] == 0) begin
                if (m_arm[k]) begin
                    m_rep[k] = repeat_en[k] ? m_rep[k] + 1 : 0;
                    if (m_rep[k] == RC) begin
                        e_rpt[k] = 1'b1;
                        m_rep[k] = 0;
                    end
                end
                if (m_hold[k] < LC) begin
                    m_hold[k]++;
                    if (m_hold[k] == LC) begin
                        e_lng[k] = 1'b1;
                        m_arm[k] = 1'b1;
                    end
                end
            end
            if (m_s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == DC) begin
                    m_lvl[k] = m_s;
                    m_run[k] = 0;
                    m_hold[k] = 0;
                    if (m_s) e_prs[k] = 1'b1;
                    else begin
                        e_rel[k] = 1'b1;
                        m_arm[k] = 1'b0;
                        m_rep[k] = 0;
                    end
                end
            end else begin
                m_run[k] = 0;
            end
            e_lvl[k] = m_lvl[k];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            for (int j = 0; j < SS; j++) m_sh[k][j] = 1'b0;
            m_lvl[k] = 1'b0; m_run[k] = 0; m_hold[k] = 0;
            m_rep[k] = 0; m_arm[k] = 1'b0;
        end
        e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else model_step();
        end
    end

    initial begin
        for (int k = 0; k < NK; k++) begin
            cnt_prs[k] = 0; cnt_rel[k] = 0; cnt_lng[k] = 0; cnt_rpt[k] = 0;
        end
        forever begin
            @(negedge CLK);
            checks++;
            if ({level_out, press_out, release_out, long_out, repeat_out} ===
                {e_lvl, e_prs, e_rel, e_lng, e_rpt}) begin
                passes++;
            end else begin
                $display("FAIL cycle_cmp t=%0t lvl %b/%b prs %b/%b rel %b/%b lng %b/%b rpt %b/%b (got/exp)",
                         $time, level_out, e_lvl, press_out, e_prs, release_out, e_rel,
                         long_out, e_lng, repeat_out, e_rpt);
            end
            for (int k = 0; k < NK; k++) begin
                cnt_prs[k] += int'(press_out[k]);
                cnt_rel[k] += int'(release_out[k]);
                cnt_lng[k] += int'(long_out[k]);
                cnt_rpt[k] += int'(repeat_out[k]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    // kind: 0 press, 1 release, 2 long, 3 repeat. n = edges waited, -1 on timeout.
    task automatic wait_pulse(input int k, input int kind, input int maxc, output int n);
        logic [NK-1:0] v;
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge CLK);
            case (kind)
                0: v = press_out;
                1: v = release_out;
                2: v = long_out;
                default: v = repeat_out;
            endcase
            if (v[k]) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int n;
        int snap_a, snap_b, snap_c;
        logic [5:0] pat;
        int run_left [NK];

        repeat (3) @(negedge CLK);
        chk("reset_outputs", int'({level_out, press_out, release_out, long_out, repeat_out}), 0);
        RST = 1'b0;
        @(negedge CLK);

        // Clean press on key0, no repeat enable
        keys_in[0] = 1'b1;
        wait_pulse(0, 0, 20, n);
        chk("s1_press_latency", n, 6);
        chk("s1_model_press", int'(e_prs[0]), 1);
        chk("s1_level_high", int'(level_out[0]), 1);
        wait_pulse(0, 2, 40, n);
        chk("s1_long_latency", n, 20);
        snap_a = cnt_rpt[0];
        repeat (14) @(negedge CLK);
        keys_in[0] = 1'b0;
        wait_pulse(0, 1, 20, n);
        chk("s1_release_latency", n, 6);
        chk("s1_level_low", int'(level_out[0]), 0);
        @(posedge CLK);
        chk("s1_no_repeat", cnt_rpt[0] - snap_a, 0);

        // Bounce 1-0-1-1-0-1 then stable high
        repeat (5) @(negedge CLK);
        snap_a = cnt_prs[0];
        pat = 6'b101101;
        for (int i = 0; i < 5; i++) begin
            keys_in[0] = pat[5-i];
            @(negedge CLK);
        end
        keys_in[0] = 1'b1;
        wait_pulse(0, 0, 20, n);
        chk("s2_press_after_bounce", n, 6);
        repeat (8) @(negedge CLK);
        @(posedge CLK);
        chk("s2_single_press", cnt_prs[0] - snap_a, 1);
        @(negedge CLK);
        keys_in[0] = 1'b0;
        wait_pulse(0, 1, 20, n);
        chk("s2_release_latency", n, 6);

        // Hold key1 with auto-repeat
        repeat (5) @(negedge CLK);
        repeat_en[1] = 1'b1;
        snap_a = cnt_lng[1];
        snap_b = cnt_rpt[1];
        keys_in[1] = 1'b1;
        wait_pulse(1, 0, 20, n);
        chk("s3_press_latency", n, 6);
        wait_pulse(1, 2, 40, n);
        chk("s3_long_latency", n, 20);
        chk("s3_model_long", int'(e_lng[1]), 1);
        for (int r = 0; r < 3; r++) begin
            wait_pulse(1, 3, 20, n);
            chk("s3_repeat_interval", n, 8);
        end
        repeat (10) @(negedge CLK);
        keys_in[1] = 1'b0;
        wait_pulse(1, 1, 20, n);
        chk("s3_release_latency", n, 6);
        @(posedge CLK);
        chk("s3_one_long", cnt_lng[1] - snap_a, 1);
        chk("s3_repeat_count", cnt_rpt[1] - snap_b, 4);
        @(negedge CLK);
        repeat_en[1] = 1'b0;

        // 2-cycle low glitch while key0 held
        repeat (5) @(negedge CLK);
        keys_in[0] = 1'b1;
        wait_pulse(0, 0, 20, n);
        chk("s4_press_latency", n, 6);
        snap_a = cnt_prs[0];
        snap_b = cnt_rel[0];
        repeat (5) @(negedge CLK);
        keys_in[0] = 1'b0;
        repeat (2) @(negedge CLK);
        keys_in[0] = 1'b1;
        wait_pulse(0, 2, 40, n);
        chk("s4_long_shifted", n, 15);
        @(posedge CLK);
        chk("s4_no_release", cnt_rel[0] - snap_b, 0);
        chk("s4_no_second_press", cnt_prs[0] - snap_a, 0);
        @(negedge CLK);
        keys_in[0] = 1'b0;
        wait_pulse(0, 1, 20, n);
        chk("s4_release_latency", n, 6);

        // Both keys together, then reset mid-hold
        repeat (5) @(negedge CLK);
        keys_in = 2'b11;
        wait_pulse(0, 0, 20, n);
        chk("s5_press_latency", n, 6);
        chk("s5_press_both", int'(press_out), 3);
        repeat (8) @(negedge CLK);
        snap_c = cnt_rel[0] + cnt_rel[1];
        #2 RST = 1'b1;
        #1 chk("s5_reset_outputs", int'({level_out, press_out, release_out, long_out, repeat_out}), 0);
        keys_in = '0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        @(posedge CLK);
        chk("s5_no_release_after_reset", cnt_rel[0] + cnt_rel[1] - snap_c, 0);
        @(negedge CLK);

        // Random key activity against the model
        for (int k = 0; k < NK; k++) run_left[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (run_left[k] == 0) begin
                    keys_in[k] = ~keys_in[k];
                    run_left[k] = ($urandom_range(0, 9) == 0) ?
                                  int'($urandom_range(25, 70)) : int'($urandom_range(1, 7));
                end
                run_left[k]--;
            end
            if ($urandom_range(0, 31) == 0) repeat_en = NK'($urandom);
            @(negedge CLK);
        end
        keys_in = '0;
        repeat (20) @(negedge CLK);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
